// File: rtl/country_sensor_request_if.sv
// Bus between the country-road sensor front end and its environment.
// The master drives the raw detector and the observed country light; the
// slave (the sensor front end) returns the request and status outputs.
interface country_sensor_request_if;
    logic       raw_det;
    logic [1:0] contry;
    logic       X;
    logic       det_clean;
    logic [7:0] req_count;
    logic       sensor_fault;

    modport master (
        output raw_det,
        output contry,
        input  X,
        input  det_clean,
        input  req_count,
        input  sensor_fault
    );

    modport slave (
        input  raw_det,
        input  contry,
        output X,
        output det_clean,
        output req_count,
        output sensor_fault
    );
endinterface

// File: rtl/country_sensor_request.sv
// Country-road sensor front end: synchronises and debounces the loop
// detector, latches a car-present request (X) until the country light is
// seen GREEN, then follows live presence until country leaves GREEN.
// Optional feature macro: STUCK_DETECT_EN (stuck-detector fault flag).
module country_sensor_request #(
    parameter int unsigned DEBOUNCE_CYCLES = 4,
    parameter int unsigned STUCK_CYCLES    = 1000,
    parameter int unsigned CNT_W           = 10
) (
    input logic                     clk,
    input logic                     clr,
    country_sensor_request_if.slave bus
);

    // Elaboration-time sanity checks on the configuration.
    if (DEBOUNCE_CYCLES < 1) begin : g_bad_debounce
        $error("DEBOUNCE_CYCLES must be at least 1");
    end
    if ((STUCK_CYCLES < 1) || (STUCK_CYCLES > ((1 << CNT_W) - 1))) begin : g_bad_stuck
        $error("STUCK_CYCLES must be >= 1 and fit in CNT_W bits");
    end

    localparam logic [CNT_W-1:0] DB_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [1:0] {StIdle, StPending, StServing} state_e;

    logic             sync1;
    logic             sync2;
    logic [CNT_W-1:0] db_cnt;
    logic             det_clean_r;
    state_e           state;
    logic             x_r;
    logic [7:0]       req_count_r;
    logic             fault_r;
    logic             fault_next;
    logic             green;

    // contry==11 is illegal and deliberately not GREEN.
    assign green = (bus.contry == 2'b10);

    // Two-flop synchroniser for the asynchronous detector input.
    always_ff @(posedge clk) begin
        if (clr) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
        end else begin
            sync1 <= bus.raw_det;
            sync2 <= sync1;
        end
    end

    // Debounce: flip det_clean after DEBOUNCE_CYCLES consecutive mismatches.
    always_ff @(posedge clk) begin
        if (clr) begin
            db_cnt      <= '0;
            det_clean_r <= 1'b0;
        end else if (sync2 == det_clean_r) begin
            db_cnt <= '0;
        end else if (db_cnt == DB_MAX) begin
            db_cnt      <= '0;
            det_clean_r <= ~det_clean_r;
        end else begin
            db_cnt <= db_cnt + 1'b1;
        end
    end

`ifdef STUCK_DETECT_EN
    localparam logic [CNT_W-1:0] STUCK_MAX = CNT_W'(STUCK_CYCLES - 1);

    logic [CNT_W-1:0] stuck_cnt;

    // Fault asserts on the edge that completes STUCK_CYCLES high cycles.
    always_comb begin
        fault_next = fault_r | (det_clean_r && (stuck_cnt == STUCK_MAX));
    end

    // Count consecutive det_clean-high cycles; fault is sticky until clr.
    always_ff @(posedge clk) begin
        if (clr) begin
            stuck_cnt <= '0;
            fault_r   <= 1'b0;
        end else begin
            fault_r <= fault_next;
            if (!det_clean_r) begin
                stuck_cnt <= '0;
            end else if (stuck_cnt != STUCK_MAX) begin
                stuck_cnt <= stuck_cnt + 1'b1;
            end
        end
    end
`else
    // No stuck detection: fault never raised, FSM never forced.
    always_comb begin
        fault_next = 1'b0;
    end

    // Keep the flag as a constant-zero register for a uniform output path.
    always_ff @(posedge clk) begin
        fault_r <= 1'b0;
    end
`endif

    // Request FSM; X is registered from the next-state decision.
    always_ff @(posedge clk) begin
        if (clr) begin
            state       <= StIdle;
            x_r         <= 1'b0;
            req_count_r <= 8'h00;
        end else if (fault_next) begin
            // Forced idle while faulted; req_count frozen.
            state <= StIdle;
            x_r   <= 1'b0;
        end else begin
            unique case (state)
                StIdle: begin
                    // A coincident GREEN is ignored here; served next cycle.
                    if (det_clean_r) begin
                        state <= StPending;
                        x_r   <= 1'b1;
                    end else begin
                        x_r <= 1'b0;
                    end
                end
                StPending: begin
                    if (green) begin
                        state <= StServing;
                        x_r   <= det_clean_r;
                        if (req_count_r != 8'hFF) begin
                            req_count_r <= req_count_r + 8'd1;
                        end
                    end else begin
                        x_r <= 1'b1;
                    end
                end
                StServing: begin
                    if (!green) begin
                        state <= StIdle;
                        x_r   <= 1'b0;
                    end else begin
                        x_r <= det_clean_r;
                    end
                end
                default: begin
                    state <= StIdle;
                    x_r   <= 1'b0;
                end
            endcase
        end
    end

    assign bus.X            = x_r;
    assign bus.det_clean    = det_clean_r;
    assign bus.req_count    = req_count_r;
    assign bus.sensor_fault = fault_r;

endmodule

// File: tb/tb_country_sensor_request.sv
// Directed bench for country_sensor_request with hand-computed expectations.
module tb_country_sensor_request;

    logic clk;
    logic clr;
    int   checks;
    int   failures;

    country_sensor_request_if bus ();

    country_sensor_request #(
        .DEBOUNCE_CYCLES (4),
        .STUCK_CYCLES    (16),
        .CNT_W           (10)
    ) dut (
        .clk (clk),
        .clr (clr),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, obs, exp);
        end
    endtask

    // Advance n rising edges, then settle 1 time unit past the last edge.
    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
        end
        #1;
    endtask

    task automatic pulse_clr();
        clr = 1'b1;
        tick(1);
        clr = 1'b0;
    endtask

    initial begin
        checks      = 0;
        failures    = 0;
        clr         = 1'b1;
        bus.raw_det = 1'b1;
        bus.contry  = 2'b00;

        // 1: reset with detector active
        tick(2);
        check_eq("rst_x", {31'd0, bus.X}, 32'd0);
        check_eq("rst_det", {31'd0, bus.det_clean}, 32'd0);
        check_eq("rst_cnt", {24'd0, bus.req_count}, 32'd0);
        check_eq("rst_fault", {31'd0, bus.sensor_fault}, 32'd0);
        clr         = 1'b0;
        bus.raw_det = 1'b0;
        tick(3);

        // 2: 3-cycle glitch must be filtered
        bus.raw_det = 1'b1;
        tick(3);
        bus.raw_det = 1'b0;
        tick(2);
        check_eq("glitch_mid_det", {31'd0, bus.det_clean}, 32'd0);
        tick(8);
        check_eq("glitch_det", {31'd0, bus.det_clean}, 32'd0);
        check_eq("glitch_x", {31'd0, bus.X}, 32'd0);

        // 3: request/serve/re-request with detector held
        bus.raw_det = 1'b1;
        tick(5);
        check_eq("req_det_e5", {31'd0, bus.det_clean}, 32'd0);
        tick(1);
        check_eq("req_det_e6", {31'd0, bus.det_clean}, 32'd1);
        check_eq("req_x_e6", {31'd0, bus.X}, 32'd0);
        tick(1);
        check_eq("req_x_e7", {31'd0, bus.X}, 32'd1);
        bus.contry = 2'b10;
        tick(1);
        check_eq("serve_cnt", {24'd0, bus.req_count}, 32'd1);
        check_eq("serve_x", {31'd0, bus.X}, 32'd1);
        tick(3);
        check_eq("serve_hold_cnt", {24'd0, bus.req_count}, 32'd1);
        bus.contry = 2'b01;
        tick(1);
        check_eq("leave_x", {31'd0, bus.X}, 32'd0);
        tick(1);
        check_eq("rereq_x", {31'd0, bus.X}, 32'd1);
        check_eq("rereq_cnt", {24'd0, bus.req_count}, 32'd1);
        bus.contry = 2'b10;
        tick(1);
        check_eq("rereq_serve_cnt", {24'd0, bus.req_count}, 32'd2);

        // 4: request latched after detector drops
        bus.contry  = 2'b00;
        bus.raw_det = 1'b0;
        pulse_clr();
        bus.raw_det = 1'b1;
        tick(8);
        bus.raw_det = 1'b0;
        tick(50);
        check_eq("latch_x", {31'd0, bus.X}, 32'd1);
        check_eq("latch_det", {31'd0, bus.det_clean}, 32'd0);
        bus.contry = 2'b10;
        tick(1);
        check_eq("latch_serve_x", {31'd0, bus.X}, 32'd0);
        check_eq("latch_serve_cnt", {24'd0, bus.req_count}, 32'd1);
        bus.contry = 2'b00;
        tick(2);
        check_eq("latch_idle_x", {31'd0, bus.X}, 32'd0);

        // 5: reset while PENDING
        bus.raw_det = 1'b1;
        tick(7);
        check_eq("midrst_pre_x", {31'd0, bus.X}, 32'd1);
        check_eq("midrst_pre_cnt", {24'd0, bus.req_count}, 32'd1);
        pulse_clr();
        check_eq("midrst_x", {31'd0, bus.X}, 32'd0);
        check_eq("midrst_cnt", {24'd0, bus.req_count}, 32'd0);
        check_eq("midrst_det", {31'd0, bus.det_clean}, 32'd0);
        tick(1);
        check_eq("midrst_idle_x", {31'd0, bus.X}, 32'd0);

        // Coincident det_clean rise and GREEN in IDLE: pend first, serve next
        bus.raw_det = 1'b0;
        pulse_clr();
        bus.contry  = 2'b10;
        bus.raw_det = 1'b1;
        tick(6);
        check_eq("coin_det", {31'd0, bus.det_clean}, 32'd1);
        tick(1);
        check_eq("coin_pend_x", {31'd0, bus.X}, 32'd1);
        check_eq("coin_pend_cnt", {24'd0, bus.req_count}, 32'd0);
        tick(1);
        check_eq("coin_serve_cnt", {24'd0, bus.req_count}, 32'd1);

        // Illegal contry=11 never advances; raw_det toggling has no effect
        bus.contry  = 2'b00;
        bus.raw_det = 1'b0;
        pulse_clr();
        bus.raw_det = 1'b1;
        tick(7);
        bus.contry = 2'b11;
        for (int i = 0; i < 6; i++) begin
            bus.raw_det = ~bus.raw_det;
            tick(1);
        end
        check_eq("ill_x", {31'd0, bus.X}, 32'd1);
        check_eq("ill_cnt", {24'd0, bus.req_count}, 32'd0);

`ifndef STUCK_DETECT_EN
        // req_count saturation, and fault stays 0 with long presence
        bus.raw_det = 1'b1;
        bus.contry  = 2'b00;
        tick(8);
        for (int i = 0; i < 260; i++) begin
            bus.contry = 2'b10;
            tick(1);
            bus.contry = 2'b00;
            tick(2);
        end
        check_eq("sat_cnt", {24'd0, bus.req_count}, 32'd255);
        check_eq("nofault", {31'd0, bus.sensor_fault}, 32'd0);
        check_eq("sat_x", {31'd0, bus.X}, 32'd1);
`else
        // 6: stuck detector with STUCK_CYCLES=16
        bus.contry  = 2'b00;
        bus.raw_det = 1'b0;
        pulse_clr();
        bus.raw_det = 1'b1;
        tick(6);
        check_eq("stk_det", {31'd0, bus.det_clean}, 32'd1);
        tick(15);
        check_eq("stk_pre_fault", {31'd0, bus.sensor_fault}, 32'd0);
        check_eq("stk_pre_x", {31'd0, bus.X}, 32'd1);
        tick(1);
        check_eq("stk_fault", {31'd0, bus.sensor_fault}, 32'd1);
        check_eq("stk_x", {31'd0, bus.X}, 32'd0);
        bus.raw_det = 1'b0;
        tick(10);
        check_eq("stk_sticky", {31'd0, bus.sensor_fault}, 32'd1);
        pulse_clr();
        check_eq("stk_clr", {31'd0, bus.sensor_fault}, 32'd0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
